// File: rtl/xc_sha256_msched.sv
// SHA-256 message schedule: loads 16 words, emits W[0..NWORDS-1] one per cycle.
// First word valid the cycle after the 16th load; out_data/out_last/window hold while out_ready=0.
module xc_sha256_msched #(
  parameter int NWORDS = 64
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        abort,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [5:0] LAST_CNT = 6'(NWORDS - 1);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] w [16];
  logic        in_fire;
  logic        out_fire;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Reset is folded in so every output reads zero while reset is held.
  assign in_ready  = (state == IDLE || state == LOAD) && !abort && !g_reset;
  assign out_valid = (state == RUN);
  assign out_last  = (state == RUN) && (cnt == LAST_CNT);
  assign busy      = (state != IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // The first 16 words echo w[0]; rotating them back in rebuilds the window.
  always_comb begin
    out_data = '0;
    if (state == RUN) begin
      if (cnt < 6'd16) out_data = w[0];
      else out_data = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (abort) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= in_data;
            cnt   <= 6'd1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (in_fire) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= in_data;
            if (cnt == 6'd15) begin
              cnt   <= '0;
              state <= RUN;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        RUN: begin
          if (out_fire) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= out_data;
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xc_sha256_msched.sv
// Directed + randomized bench for xc_sha256_msched against an array-based schedule model.
module tb_xc_sha256_msched;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        abort = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] blk [16];
  logic [31:0] exp_w [64];
  logic [31:0] got [64];

  xc_sha256_msched #(.NWORDS(64)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .abort(abort), .busy(busy)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void build_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[t];
      else exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                    + exp_w[t-7]
                    + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                    + exp_w[t-16];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_ref();
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_ref();
  endtask

  // Every task starts and ends just after a rising edge.
  task automatic send(input int nw, input bit gaps);
    logic r;
    for (int k = 0; k < nw; k++) begin
      if (gaps) begin
        repeat ($urandom_range(1, 3)) begin
          in_valid = 1'b0;
          @(negedge g_clk);
          @(posedge g_clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = blk[k];
      r = 1'b0;
      for (int c = 0; c < 20 && !r; c++) begin
        @(negedge g_clk);
        r = in_ready;
        if (k == 15 && r) chk("no_run_before_16", {31'b0, out_valid}, 32'd0);
        @(posedge g_clk); #1;
      end
      if (!r) chk("in_ready_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle 1-0-1, 2: random
  task automatic recv(input int mode, input int stop_at);
    int idx = 0;
    bit stalled = 0;
    logic [31:0] held = '0;
    logic        held_last = 1'b0;
    for (int c = 0; c < 1000 && idx < stop_at; c++) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom % 2);
      @(negedge g_clk);
      if (c == 0) chk("first_valid", {31'b0, out_valid}, 32'd1);
      chk("in_ready_run", {31'b0, in_ready}, 32'd0);
      if (stalled) begin
        chk("stall_data", out_data, held);
        chk("stall_last", {31'b0, out_last}, {31'b0, held_last});
      end
      if (out_valid) chk("last_flag", {31'b0, out_last}, (idx == 63) ? 32'd1 : 32'd0);
      else chk("valid_drop", {31'b0, out_valid}, 32'd1);
      if (out_valid && out_ready) begin
        got[idx] = out_data;
        chk($sformatf("w%0d", idx), out_data, exp_w[idx]);
        idx++;
        stalled = 0;
      end else begin
        held = out_data;
        held_last = out_last;
        stalled = 1;
      end
      @(posedge g_clk); #1;
    end
    out_ready = 1'b0;
    chk("recv_count", 32'(idx), 32'(stop_at));
    if (stop_at == 64) begin
      @(negedge g_clk);
      chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_valid", {31'b0, out_valid}, 32'd0);
      @(posedge g_clk); #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_out_last"}, {31'b0, out_last}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge g_clk);
    #1;
    @(negedge g_clk);
    chk_all_zero("reset");
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge g_clk); #1;

    // "abc", always ready
    set_abc();
    send(16, 0);
    recv(0, 64);
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000f0000);
    chk("abc_w18", got[18], 32'h7da86405);

    // "abc", toggling ready
    send(16, 0);
    recv(1, 64);
    chk("tog_w18", got[18], 32'h7da86405);

    // back-to-back zero block then "abc"
    for (int i = 0; i < 16; i++) blk[i] = '0;
    build_ref();
    send(16, 0);
    recv(0, 64);
    set_abc();
    send(16, 0);
    recv(0, 64);

    // abort at RUN cnt==20, with an input word offered
    send(16, 0);
    recv(0, 20);
    abort = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hdeadbeef;
    @(negedge g_clk);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge g_clk); #1;
    abort = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    @(negedge g_clk);
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(posedge g_clk); #1;
    send(16, 0);
    recv(0, 64);
    chk("abort_w17", got[17], 32'h000f0000);

    // abort during LOAD with a word offered: the word must not be taken
    send(5, 0);
    abort = 1'b1; in_valid = 1'b1; in_data = 32'h12345678;
    @(negedge g_clk);
    chk("abort_load_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge g_clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge g_clk);
    chk("abort_load_busy", {31'b0, busy}, 32'd0);
    @(posedge g_clk); #1;
    send(16, 0);
    recv(0, 64);

    // reset during LOAD after 7 words
    send(7, 0);
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk_all_zero("midreset");
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    send(16, 0);
    recv(0, 64);

    // gapped input
    send(16, 1);
    recv(0, 64);

    // random blocks, gaps and backpressure
    for (int b = 0; b < 4; b++) begin
      set_rand();
      send(16, 1'($urandom % 2));
      recv(2, 64);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
